// File: rtl/spi_slave_if_pkg.sv
// Shared constants for the SPI slave interface: FIFO depth limits,
// FSM state encodings and the byte value used when no data is available.
package spi_slave_if_pkg;

    localparam int FIFO_DEPTH_MIN = 4;
    localparam int FIFO_DEPTH_MAX = 128;

    localparam logic [7:0] IDLE_BYTE = 8'h00;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= FIFO_DEPTH_MIN) && (depth <= FIFO_DEPTH_MAX) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead byte FIFO with occupancy count; a read and a write in the
// same cycle both take effect, and a write is dropped only when full.
module sync_fifo
    import spi_slave_if_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = rd_en & ~empty;
    // A full FIFO can still accept a byte when the head leaves in the same cycle.
    assign do_wr = wr_en & (~full | do_rd);

    assign rd_data = empty ? IDLE_BYTE : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave (mode 0/2) with RX/TX byte FIFOs, oversampled on clk.
// Optional overrun/underrun counter output enabled by SPI_SLAVE_OVERRUN_CNT_EN.
module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter bit CPOL       = 1'b0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       n_cs,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] in_data,
    input  logic       in_ena,
    output logic       tx_full,
    output logic [7:0] out_data,
    output logic       have_msg,
    output logic [7:0] len,
    input  logic       enc_rdreq
`ifdef SPI_SLAVE_OVERRUN_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("spi_slave_if: FIFO_DEPTH must be a power of two in 4..128");
    end

    // Bits [1:0] synchronise, bit [2] holds the previous synchronised level.
    logic [2:0]    cs_sr;
    logic [2:0]    sclk_sr;
    logic [2:0]    mosi_sr;
    logic [1:0]    sync_fill;
    logic          cs_armed;
    logic          cs_fall;
    logic          cs_rise;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          lead;
    logic          trail;

    state_t        state;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic [2:0]    bit_cnt;
    logic          rx_push;
    logic          reload;
    logic          load_now;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sr     <= 3'b111;
            sclk_sr   <= {3{CPOL}};
            mosi_sr   <= 3'b000;
            sync_fill <= 2'b00;
            cs_armed  <= 1'b0;
        end else begin
            cs_sr     <= {cs_sr[1:0], n_cs};
            sclk_sr   <= {sclk_sr[1:0], sclk};
            mosi_sr   <= {mosi_sr[1:0], mosi};
            sync_fill <= {sync_fill[0], 1'b1};
            // A chip select still low when reset lifts must not start a frame.
            if (sync_fill[1] & cs_sr[1]) cs_armed <= 1'b1;
        end
    end

    assign cs_fall   = cs_armed & cs_sr[2] & ~cs_sr[1];
    assign cs_rise   = ~cs_sr[2] & cs_sr[1];
    assign sclk_rise = ~sclk_sr[2] & sclk_sr[1];
    assign sclk_fall = sclk_sr[2] & ~sclk_sr[1];
    assign lead      = CPOL ? sclk_fall : sclk_rise;
    assign trail     = CPOL ? sclk_rise : sclk_fall;

    assign load_now = ~cs_rise &
                      ((state == ST_LOAD) | ((state == ST_SHIFT) & trail & reload));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            miso     <= 1'b0;
            tx_shift <= IDLE_BYTE;
            rx_shift <= IDLE_BYTE;
            bit_cnt  <= 3'd0;
            rx_push  <= 1'b0;
            reload   <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (cs_rise) begin
                state  <= ST_IDLE;
                miso   <= 1'b0;
                reload <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        miso <= 1'b0;
                        if (cs_fall) state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        tx_shift <= tx_head;
                        miso     <= tx_head[7];
                        bit_cnt  <= 3'd0;
                        reload   <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (lead) begin
                            rx_shift <= {rx_shift[6:0], mosi_sr[2]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_push <= 1'b1;
                                reload  <= 1'b1;
                            end
                        end else if (trail) begin
                            if (reload) begin
                                tx_shift <= tx_head;
                                miso     <= tx_head[7];
                                reload   <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                miso     <= tx_shift[6];
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_ena),
        .wr_data (in_data),
        .rd_en   (load_now),
        .rd_data (tx_head),
        .count   (tx_count)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (rx_shift),
        .rd_en   (enc_rdreq),
        .rd_data (out_data),
        .count   (rx_count)
    );

    assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
    assign have_msg = (rx_count != '0);
    assign len      = 8'(rx_count);

`ifdef SPI_SLAVE_OVERRUN_CNT_EN
    logic       rx_drop;
    logic       tx_empty_load;
    logic [8:0] err_sum;

    assign rx_drop       = rx_push & (rx_count == CW'(FIFO_DEPTH)) & ~(enc_rdreq & have_msg);
    assign tx_empty_load = load_now & (tx_count == '0);
    assign err_sum       = {1'b0, err_cnt} + 9'(rx_drop) + 9'(tx_empty_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else begin
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end
`endif

endmodule
